// File: rtl/prio_enc_rr_arb.sv
// prio_enc_rr_arb
// Registered priority encoder / arbiter with a valid/ready output handshake.
// An N-bit request vector is reduced to a W-bit index, a one-hot grant and a
// valid flag. Two selection modes are available: fixed priority, where the
// highest index wins, and round-robin, which scans downward from a rotating
// base. The registered result stays stable until the consumer takes it.
//
// Ports:
//   clk        in   1  clock, all state updates on the rising edge
//   rst_n      in   1  synchronous reset, active-low
//   req        in   N  request vector, bit i is requester i
//   mode       in   1  0 = fixed priority (highest index), 1 = round-robin
//   out_ready  in   1  consumer accepts the current result
//   out_valid  out  1  out_idx / out_gnt hold a valid result
//   out_idx    out  W  index of the granted requester
//   out_gnt    out  N  one-hot grant, zero when out_valid is low
//
// W is derived from N and is not meant to be overridden.

module prio_enc_rr_arb #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_gnt
);

    localparam logic [W-1:0] IDX_ONE  = W'(1);
    localparam logic [W-1:0] IDX_LAST = W'(N - 1);

    logic         accept;
    logic         load;
    logic [W-1:0] ptr;
    logic [W-1:0] base;
    logic [W-1:0] cand;
    logic [W-1:0] fix_idx;
    logic [W-1:0] rr_idx;
    logic         rr_found;
    logic [W-1:0] sel_idx;
    logic [N-1:0] sel_gnt;

    assign accept = out_valid & out_ready;
    assign load   = ~out_valid | out_ready;

    // Fixed priority: the loop runs upward, so the last set bit seen, which is
    // the highest index, ends up selected.
    always_comb begin
        fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                fix_idx = W'(i);
            end
        end
    end

    // Round-robin: scan base, base-1, ... with natural W-bit wrap. When the
    // current result is being consumed this same cycle, start just below it
    // rather than at the registered ptr so back-to-back grants rotate fairly.
    always_comb begin
        base     = accept ? (out_idx - IDX_ONE) : ptr;
        cand     = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = base - W'(k);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Mode mux and one-hot expansion; an empty request yields all zeros so
    // no don't-care value ever reaches the output registers.
    always_comb begin
        sel_idx = '0;
        sel_gnt = '0;
        if (|req) begin
            sel_idx          = mode ? rr_idx : fix_idx;
            sel_gnt[sel_idx] = 1'b1;
        end
    end

    // Output registers and the round-robin pointer. The pointer follows every
    // accepted grant regardless of mode, so switching modes keeps its history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_gnt   <= '0;
            ptr       <= IDX_LAST;
        end else begin
            if (accept) begin
                ptr <= out_idx - IDX_ONE;
            end
            if (load) begin
                out_valid <= |req;
                out_idx   <= sel_idx;
                out_gnt   <= sel_gnt;
            end
        end
    end

endmodule

// File: doc/prio_enc_rr_arb.md
Name: prio_enc_rr_arb

Overview:
- Parametrised, registered successor to the 8-to-3 priority encoder.
- Encodes an N-bit request vector into a W-bit index, a one-hot grant and a valid flag.
- Two modes: fixed priority, where the MSB wins, and round-robin.
- The encoded result is presented on a valid/ready output handshake and held stable until it is consumed.
- Sits between a request-collecting stage and a consumer that may stall.

Parameters:
- N, 8, number of request lines; a power of 2, ≥ 2.
- W, $clog2(N), index width; derived, must not be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req  in  N  request vector; bit i is requester i.
- mode  in  1  0 = fixed priority (highest index wins), 1 = round-robin.
- out_ready  in  1  consumer accepts the current result.
- out_valid  out  1  out_idx / out_gnt hold a valid encoded result.
- out_idx  out  W  encoded index of the granted requester.
- out_gnt  out  N  one-hot grant; equals 1 << out_idx when out_valid = 1, else 0.

Behaviour:

Reset (rst_n = 0 at a clk edge):
- out_valid = 0, out_idx = 0, out_gnt = 0, ptr = N-1.
- Reset overrides every other event in that cycle, including an in-flight handshake.
- Reset mid-operation discards any held result.

Definitions:
- accept = out_valid & out_ready.
- load = ~out_valid | out_ready.

Sampling (latency 1):
- On an edge with load = 1:
  - If req != 0: out_valid ← 1 and out_idx/out_gnt ← the selected requester.
  - Else: out_valid ← 0 and out_idx/out_gnt ← 0.
- On an edge with load = 0, all outputs hold their values, even if req changes or drops. A granted result is never retracted.

Selection, fixed (mode = 0):
- Highest set bit of req wins; identical to the casex encoder for N = 8.
- ptr is ignored but still updated.

Selection, round-robin (mode = 1):
- Search starts at base and scans descending with wrap: base, base-1, …, 0, N-1, …, base+1. The first set bit wins.
- base = (out_idx - 1) mod N if accept is true in this cycle, else ptr. This gives back-to-back fairness without a bubble cycle.

Pointer:
- On accept, ptr ← (out_idx - 1) mod N, regardless of mode.
- Wrap: out_idx = 0 gives ptr = N-1.
- No change without accept.

Mode change:
- Sampled only on load edges. A held result is unaffected.
- ptr is retained across mode switches.

Simultaneous events:
- Accept plus a new req in the same cycle gives a new result the next cycle with out_valid staying 1; throughput is 1 per cycle.
- Accept with req = 0 gives out_valid = 0 the next cycle.
- All N bits set: fixed mode grants N-1 every time; round-robin rotates N-1, N-2, …, 0, N-1.
- A single request always wins immediately, whatever ptr is.

Arithmetic:
- All index arithmetic is mod N; W-bit wrap is natural because N is a power of 2.

Invariants:
- out_gnt is one-hot or zero; zero if and only if out_valid = 0.
- No X is ever driven on any output. The don't-care output of the combinational encoder is replaced by 0.

Test Plan:
1. N = 8, mode 0, out_ready = 1; drive req = 8'b0001_0110, then 8'b1000_0000, then 0 → out_idx = 4 then 7, out_valid 1, 1, then 0; out_gnt = 8'h10, 8'h80, then 8'h00.
2. Mode 0, out_ready = 0; req = 8'h04 then 8'h80 → out_idx stays 2 while stalled. Raise out_ready for one cycle → out_idx = 7 the next cycle.
3. Mode 1, out_ready = 1, req = 8'hFF held → out_idx sequence 7, 6, 5, 4, 3, 2, 1, 0, 7, no bubbles.
4. Mode 1, req = 8'b1000_0001 held, ready toggling 1, 0, 1 → grants 7, 0 (held for 2 cycles), 7; ptr wraps correctly from index 0.
5. Mid-stream reset: mode 1, req = 8'hFF, rst_n = 0 for one edge while out_valid = 1 and out_ready = 0 → outputs 0 after that edge; first grant after release is 7.
6. Switch mode 1 → 0 while stalled with out_idx = 3 and req = 8'hFF → out_idx stays 3 until accept, then becomes 7. Switch back to 1 → grant continues from the retained ptr (6).
